// File: rtl/uart_pkg.sv
// uart_pkg
// Shared UART definitions used by the receive core (and the transmitter):
// default line timing, derived bit-period constants, receiver state
// encoding and a 3-input majority helper.
package uart_pkg;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;  // 434
  localparam int HALF_BIT     = CLKS_PER_BIT / 2; // 217
  localparam int CNT_W        = 9;                // holds CLKS_PER_BIT-1

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
// Receive-side result bundle between the UART receive core and its consumer
// (the wrapper's interrupt state machine).
//   rx_data   : last correctly framed byte
//   end_flag  : 1-cycle pulse, rx_data updated this cycle
//   frame_err : 1-cycle pulse, stop bit sampled low
//   rx_busy   : receiver is not idle
// master = receive core (drives), slave = consumer (observes).
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [7:0] rx_data;
  logic       end_flag;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_data,
    output end_flag,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input end_flag,
    input frame_err,
    input rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Brings the asynchronous rx pin into the clk domain and filters it.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : raw serial pin (idle high)
//   rx_sync    : rx after the 2-flop synchroniser
//   bit_val    : majority of the last three synchronised samples
// All flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic bit_val
);

  logic       meta_reg;
  logic       sync_reg;
  logic [2:0] hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      hist_reg <= 3'b111;
    end else begin
      meta_reg <= rx;
      sync_reg <= meta_reg;
      hist_reg <= {hist_reg[1:0], sync_reg};
    end
  end

  assign rx_sync = sync_reg;
  // A single-cycle spike occupies only one history slot, so it never wins.
  assign bit_val = majority3(hist_reg);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receive front end. Detects and validates the start bit at half
// a bit period, samples each data bit and the stop bit once per bit period
// (mid-bit) using the majority-filtered line, assembles LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   rx_if      : result bundle (rx_data, end_flag, frame_err, rx_busy)
// A stop bit sampled low raises frame_err once and then parks in BREAK
// until the line returns high, so a held-low line is reported only once.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD     = uart_pkg::BAUD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_rx_core_if.master rx_if
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rx_sync;
  logic bit_val;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_sync (rx_sync),
    .bit_val (bit_val)
  );

  uart_rx_state_e   state_reg,     state_next;
  logic [CNT_W-1:0] cnt_reg,       cnt_next;
  logic [2:0]       bit_idx_reg,   bit_idx_next;
  logic [7:0]       shreg_reg,     shreg_next;
  logic [7:0]       rx_data_reg,   rx_data_next;
  logic             end_flag_reg,  end_flag_next;
  logic             frame_err_reg, frame_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      rx_data_reg   <= '0;
      end_flag_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      rx_data_reg   <= rx_data_next;
      end_flag_reg  <= end_flag_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shreg_next     = shreg_reg;
    rx_data_next   = rx_data_reg;
    end_flag_next  = 1'b0;
    frame_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_sync) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (!bit_val) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {bit_val, shreg_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (bit_val) begin
            rx_data_next  = shreg_reg;
            end_flag_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      BREAK: begin
        cnt_next = '0;
        if (rx_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign rx_if.rx_data   = rx_data_reg;
  assign rx_if.end_flag  = end_flag_reg;
  assign rx_if.frame_err = frame_err_reg;
  assign rx_if.rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Directed bench for uart_rx_core: reset, single byte with latency window,
// back-to-back frames at nominal and +/-2% bit periods, glitch rejection,
// framing error with break, and reset in the middle of a frame.
module tb_uart_rx_core;

  logic clk;
  logic rst_n;
  logic rx;

  uart_rx_core_if rx_if ();

  uart_rx_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_if (rx_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc       = 0;
  int start_cyc = 0;
  int ef_cyc    = 0;
  int ef_count  = 0;
  int fe_count  = 0;
  int both_count = 0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_if.end_flag === 1'b1) begin
      ef_count <= ef_count + 1;
      ef_cyc   <= cyc;
      got_q.push_back(rx_if.rx_data);
    end
    if (rx_if.frame_err === 1'b1) fe_count <= fe_count + 1;
    if (rx_if.end_flag === 1'b1 && rx_if.frame_err === 1'b1) both_count <= both_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting at a falling edge of clk. spike_bit >= 0
  // inserts a 1-cycle low pulse in the middle of that data bit.
  task automatic send_byte(input logic [7:0] d, input int cpb, input logic stop_bit,
                           input int spike_bit);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == spike_bit) begin
        repeat (cpb / 2) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = d[i];
        repeat (cpb - cpb / 2 - 1) @(negedge clk);
      end else begin
        repeat (cpb) @(negedge clk);
      end
    end
    rx = stop_bit;
    repeat (cpb) @(negedge clk);
  endtask

  int ef_base;
  int fe_base;
  int lat;
  logic [31:0] v;
  int cpb_tab [3] = '{434, 425, 443};
  logic [7:0] b2b_tab [3] = '{8'h00, 8'hFF, 8'hA5};

  initial begin
    // Reset held while rx toggles.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (20) begin
      @(negedge clk);
      rx = ~rx;
    end
    check("rst_rx_data",   32'(rx_if.rx_data),   32'h00);
    check("rst_end_flag",  32'(rx_if.end_flag),  32'h0);
    check("rst_frame_err", 32'(rx_if.frame_err), 32'h0);
    check("rst_rx_busy",   32'(rx_if.rx_busy),   32'h0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    check("post_rst_busy", 32'(rx_if.rx_busy), 32'h0);
    check("post_rst_ef",   32'(ef_count),      32'd0);
    $display("reset: rx_data=%02h busy=%0b", rx_if.rx_data, rx_if.rx_busy);

    // Single byte 0x55 with latency window.
    ef_base = ef_count;
    fe_base = fe_count;
    got_q.delete();
    send_byte(8'h55, 434, 1'b1, -1);
    idle(20);
    lat = ef_cyc - start_cyc;
    check("single_ef_cnt", 32'(ef_count - ef_base), 32'd1);
    check("single_data",   32'(rx_if.rx_data),      32'h55);
    check("single_fe",     32'(fe_count - fe_base), 32'd0);
    check("single_latency", 32'(lat >= 4119 && lat <= 4127), 32'd1);
    $display("byte 55: data=%02h latency=%0d", rx_if.rx_data, lat);

    // Back-to-back 00, FF, A5 at nominal and +/-2% bit periods.
    for (int r = 0; r < 3; r++) begin
      idle(100);
      ef_base = ef_count;
      got_q.delete();
      for (int k = 0; k < 3; k++) send_byte(b2b_tab[k], cpb_tab[r], 1'b1, -1);
      idle(20);
      check($sformatf("b2b_cnt_%0d", cpb_tab[r]), 32'(ef_count - ef_base), 32'd3);
      for (int k = 0; k < 3; k++) begin
        v = (got_q.size() > 0) ? 32'(got_q.pop_front()) : 32'hDEAD;
        check($sformatf("b2b_%0d_byte%0d", cpb_tab[r], k), v, 32'(b2b_tab[k]));
      end
      $display("b2b cpb=%0d: %0d frames, last data=%02h", cpb_tab[r], ef_count - ef_base,
               rx_if.rx_data);
    end

    // 100-cycle low glitch must be rejected.
    idle(100);
    ef_base = ef_count;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(600);
    check("glitch_ef",   32'(ef_count - ef_base), 32'd0);
    check("glitch_busy", 32'(rx_if.rx_busy),      32'h0);
    check("glitch_data", 32'(rx_if.rx_data),      32'hA5);
    $display("glitch: end_flags=%0d busy=%0b", ef_count - ef_base, rx_if.rx_busy);

    // 0x0F with a 1-cycle low spike in the middle of bit 2 (a '1').
    ef_base = ef_count;
    send_byte(8'h0F, 434, 1'b1, 2);
    idle(20);
    check("spike_ef",   32'(ef_count - ef_base), 32'd1);
    check("spike_data", 32'(rx_if.rx_data),      32'h0F);
    $display("spike byte: data=%02h", rx_if.rx_data);

    // Good 0x3C, then 0xC3 with a low stop bit followed by a long break.
    idle(100);
    send_byte(8'h3C, 434, 1'b1, -1);
    idle(20);
    check("pre_ferr_data", 32'(rx_if.rx_data), 32'h3C);
    ef_base = ef_count;
    fe_base = fe_count;
    send_byte(8'hC3, 434, 1'b0, -1);
    rx = 1'b0;
    repeat (10 * 434) @(negedge clk);
    check("break_busy", 32'(rx_if.rx_busy), 32'h1);
    idle(1000);
    check("ferr_fe_cnt", 32'(fe_count - fe_base), 32'd1);
    check("ferr_ef_cnt", 32'(ef_count - ef_base), 32'd0);
    check("ferr_data",   32'(rx_if.rx_data),      32'h3C);
    check("ferr_busy",   32'(rx_if.rx_busy),      32'h0);
    $display("frame error: frame_errs=%0d data=%02h", fe_count - fe_base, rx_if.rx_data);
    ef_base = ef_count;
    send_byte(8'h12, 434, 1'b1, -1);
    idle(20);
    check("after_break_ef",   32'(ef_count - ef_base), 32'd1);
    check("after_break_data", 32'(rx_if.rx_data),      32'h12);
    $display("after break: data=%02h", rx_if.rx_data);

    // Reset asserted during bit 4 of 0x81.
    idle(100);
    ef_base = ef_count;
    rx = 1'b0;
    repeat (434) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      repeat (434) @(negedge clk);
    end
    rx = 1'b0;
    repeat (200) @(negedge clk);
    check("midframe_busy", 32'(rx_if.rx_busy), 32'h1);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_rx_data",   32'(rx_if.rx_data),   32'h00);
    check("midrst_end_flag",  32'(rx_if.end_flag),  32'h0);
    check("midrst_frame_err", 32'(rx_if.frame_err), 32'h0);
    check("midrst_rx_busy",   32'(rx_if.rx_busy),   32'h0);
    rst_n = 1'b1;
    idle(1000);
    check("midrst_no_ef", 32'(ef_count - ef_base), 32'd0);
    $display("mid-frame reset: data=%02h busy=%0b", rx_if.rx_data, rx_if.rx_busy);
    send_byte(8'h81, 434, 1'b1, -1);
    idle(20);
    check("midrst_next_ef",   32'(ef_count - ef_base), 32'd1);
    check("midrst_next_data", 32'(rx_if.rx_data),      32'h81);
    $display("after mid-frame reset: data=%02h", rx_if.rx_data);

    check("never_both_flags", 32'(both_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
